// File: rtl/uart_periph_ctrl.sv
// uart_periph_ctrl
//   Memory-mapped UART controller between the MEM stage and the byte-level
//   UART rx/tx engines. Received bytes go into a small FIFO. One TX byte can
//   be held pending while the transmitter is sequenced through a
//   start/busy/done handshake. A level IRQ is raised while RX data waits.
//
//   Register map (byte addresses, exact match only):
//     BASE_ADDR + 0  TXD  W   store queues wdata[7:0] if nothing is pending
//     BASE_ADDR + 4  RXD  R   FIFO head; a load pops it
//     BASE_ADDR + 8  CON  RW  R: {overrun, rx_nonempty, tx_pending, tx_busy, irq_en}
//                             W: irq_en <= wdata[0], wdata[4] clears overrun
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   mem_rd, mem_wr   one-cycle load / store strobes from the MEM stage
//   addr, wdata      byte address and store data
//   rdata            load data, combinational from addr and state
//   rx_valid/rx_data one-cycle pulse and byte from the UART receiver
//   tx_ready         transmitter idle (1) / shifting (0)
//   tx_start/tx_data one-cycle launch pulse and the byte being sent
//   irq              irq_en & rx_nonempty
//
// Handshake with the transmitter: tx_start is high for exactly one cycle,
// and tx_data is valid from that cycle and held until the transmitter
// reports tx_ready again and the FSM returns to TX_IDLE.

module uart_periph_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0018,
  parameter int          RX_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        tx_ready,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  output logic        irq
);

  localparam int PW = $clog2(RX_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [31:0] TXD_ADDR = BASE_ADDR;
  localparam logic [31:0] RXD_ADDR = BASE_ADDR + 32'd4;
  localparam logic [31:0] CON_ADDR = BASE_ADDR + 32'd8;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_WAIT  = 2'd2,
    TX_SHIFT = 2'd3
  } tx_state_t;

  // Address decode
  logic sel_txd, sel_rxd, sel_con;
  logic txd_wr, con_wr, rxd_rd;

  assign sel_txd = (addr == TXD_ADDR);
  assign sel_rxd = (addr == RXD_ADDR);
  assign sel_con = (addr == CON_ADDR);
  assign txd_wr  = mem_wr & sel_txd;
  assign con_wr  = mem_wr & sel_con;
  assign rxd_rd  = mem_rd & sel_rxd;

  // RX FIFO
  logic [7:0]    fifo_mem [RX_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          rx_nonempty, rx_full;
  logic          pop, push, drop;
  logic          overrun;
  logic          irq_en;

  assign rx_nonempty = (count != '0);
  assign rx_full     = (count == CW'(RX_DEPTH));
  // A load on an empty FIFO returns 0 and pops nothing.
  assign pop         = rxd_rd & rx_nonempty;
  // A pop in the same cycle frees a slot, so a push into a full FIFO is kept.
  // On an empty FIFO a simultaneous push simply lands and becomes the head.
  assign push        = rx_valid & (~rx_full | pop);
  assign drop        = rx_valid & rx_full & ~pop;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= rx_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Control register. A drop in the same cycle as a clear wins, so the
  // overrun event is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_en  <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (con_wr) irq_en <= wdata[0];
      if (drop) begin
        overrun <= 1'b1;
      end else if (con_wr && wdata[4]) begin
        overrun <= 1'b0;
      end
    end
  end

  assign irq = irq_en & rx_nonempty;

  // TX path
  tx_state_t state, state_next;
  logic      wait_cnt, wait_cnt_next;
  logic      tx_pending;
  logic [7:0] tx_hold;
  logic      load_tx;
  logic      tx_busy;

  assign tx_busy = (state != TX_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= TX_IDLE;
      wait_cnt <= 1'b0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
    end
  end

  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    tx_start      = 1'b0;
    load_tx       = 1'b0;
    case (state)
      TX_IDLE: begin
        if (tx_pending && tx_ready) begin
          state_next = TX_START;
          load_tx    = 1'b1;
        end
      end
      TX_START: begin
        tx_start      = 1'b1;
        state_next    = TX_WAIT;
        wait_cnt_next = 1'b0;
      end
      TX_WAIT: begin
        // Give the transmitter up to two cycles to drop tx_ready.
        if (!tx_ready || wait_cnt) begin
          state_next = TX_SHIFT;
        end else begin
          wait_cnt_next = 1'b1;
        end
      end
      TX_SHIFT: begin
        if (tx_ready) state_next = TX_IDLE;
      end
      default: state_next = TX_IDLE;
    endcase
  end

  // The hold register refills as soon as the pending byte has moved into
  // tx_data, so a second byte can queue up while the first is shifting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_pending <= 1'b0;
      tx_hold    <= 8'h00;
      tx_data    <= 8'h00;
    end else begin
      if (load_tx) begin
        tx_data    <= tx_hold;
        tx_pending <= 1'b0;
      end else if (txd_wr && !tx_pending) begin
        tx_hold    <= wdata[7:0];
        tx_pending <= 1'b1;
      end
    end
  end

  // Load data
  always_comb begin
    rdata = 32'h0;
    if (sel_rxd && rx_nonempty) begin
      rdata = {24'h0, fifo_mem[rd_ptr]};
    end else if (sel_con) begin
      rdata = {27'h0, overrun, rx_nonempty, tx_pending, tx_busy, irq_en};
    end
  end

endmodule

// File: tb/tb_uart_periph_ctrl.sv
// Directed testbench for uart_periph_ctrl. RX bytes and TX bytes are tracked
// in expected queues; a background transmitter agent answers tx_start by
// holding tx_ready low for 10 cycles and checks each launched byte.

module tb_uart_periph_ctrl;

  localparam logic [31:0] BASE     = 32'h4000_0018;
  localparam logic [31:0] TXD      = BASE;
  localparam logic [31:0] RXD      = BASE + 32'd4;
  localparam logic [31:0] CON      = BASE + 32'd8;
  localparam int          RX_DEPTH = 4;

  // Clock / reset
  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_rd, mem_wr;
  logic [31:0] addr, wdata, rdata;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        tx_ready;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        irq;

  always #5 clk = ~clk;

  uart_periph_ctrl #(.BASE_ADDR(BASE), .RX_DEPTH(RX_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .addr(addr), .wdata(wdata), .rdata(rdata),
    .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_ready(tx_ready), .tx_start(tx_start), .tx_data(tx_data),
    .irq(irq)
  );

  // Scoreboard
  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int n_tx_starts = 0;
  int cyc = 0;
  int last_start = -100;
  int busy_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Transmitter agent: answers each start, checks byte and spacing.
  task automatic tx_agent();
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        tx_ready = 1'b1;
        busy_cnt = 0;
      end else if (tx_start) begin
        if (tx_q.size() == 0) begin
          check("tx_start_unexpected", {24'h0, tx_data}, 32'hFFFF_FFFF);
        end else begin
          check("tx_data", {24'h0, tx_data}, {24'h0, tx_q.pop_front()});
        end
        check("tx_start_spacing_ge3", 32'(cyc - last_start >= 3), 32'd1);
        last_start = cyc;
        n_tx_starts++;
        tx_ready = 1'b0;
        busy_cnt = 10;
      end else if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) tx_ready = 1'b1;
      end
    end
  endtask

  // Driver tasks
  task automatic clear_strobes();
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    clear_strobes();
    addr = a; wdata = d; mem_wr = 1'b1;
    @(posedge clk); #1;
    mem_wr = 1'b0;
  endtask

  task automatic push_rx(input logic [7:0] b, inout logic m_overrun);
    @(negedge clk);
    clear_strobes();
    rx_valid = 1'b1; rx_data = b;
    if (rx_q.size() < RX_DEPTH) rx_q.push_back(b);
    else m_overrun = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic load_rxd(input string tag);
    logic [31:0] exp;
    @(negedge clk);
    clear_strobes();
    addr = RXD; mem_rd = 1'b1;
    exp = (rx_q.size() != 0) ? {24'h0, rx_q.pop_front()} : 32'h0;
    #1 check(tag, rdata, exp);
    @(posedge clk); #1;
    mem_rd = 1'b0;
  endtask

  task automatic push_and_load(input string tag, input logic [7:0] b);
    logic [31:0] exp;
    @(negedge clk);
    clear_strobes();
    addr = RXD; mem_rd = 1'b1; rx_valid = 1'b1; rx_data = b;
    exp = (rx_q.size() != 0) ? {24'h0, rx_q.pop_front()} : 32'h0;
    rx_q.push_back(b);
    #1 check(tag, rdata, exp);
    @(posedge clk); #1;
    clear_strobes();
  endtask

  task automatic read_at(input string tag, input logic [31:0] a, input logic rd,
                         input logic [31:0] exp);
    @(negedge clk);
    clear_strobes();
    addr = a; mem_rd = rd;
    #1 check(tag, rdata, exp);
    @(posedge clk); #1;
    mem_rd = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic m_overrun;
    logic done;
    int   base_starts;
    m_overrun = 1'b0;
    clear_strobes();
    addr = CON; wdata = 32'h0; rx_data = 8'h00; tx_ready = 1'b1;
    rst_n = 1'b0;
    fork tx_agent(); join_none

    // Reset state
    #3;
    check("reset_tx_start", {31'h0, tx_start}, 32'h0);
    check("reset_tx_data", {24'h0, tx_data}, 32'h0);
    check("reset_irq", {31'h0, irq}, 32'h0);
    check("reset_rdata_con", rdata, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(1);

    // Test 1: reset while the transmitter is shifting
    store(CON, 32'h1);
    push_rx(8'h99, m_overrun);
    check("t1_irq_before_reset", {31'h0, irq}, 32'h1);
    tx_q.push_back(8'h55);
    store(TXD, 32'h55);
    idle(3);
    read_at("t1_con_in_shift", CON, 1'b0, 32'h0B);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("t1_tx_start_in_reset", {31'h0, tx_start}, 32'h0);
    check("t1_irq_in_reset", {31'h0, irq}, 32'h0);
    check("t1_tx_data_in_reset", {24'h0, tx_data}, 32'h0);
    tx_q.delete();
    rx_q.delete();
    m_overrun = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    read_at("t1_con_after_reset", CON, 1'b0, 32'h00);

    // Test 2: three bytes in, three out, then an empty load
    push_rx(8'h12, m_overrun);
    push_rx(8'h34, m_overrun);
    push_rx(8'h56, m_overrun);
    load_rxd("t2_rxd_0");
    load_rxd("t2_rxd_1");
    load_rxd("t2_rxd_2");
    load_rxd("t2_rxd_empty");
    read_at("t2_con_empty", CON, 1'b0, 32'h00);

    // Test 3: overflow sets overrun, write-1-clear
    for (int i = 0; i < 5; i++) push_rx(8'(8'h21 + i), m_overrun);
    check("t3_model_overrun", {31'h0, m_overrun}, 32'h1);
    read_at("t3_con_overrun", CON, 1'b0, 32'h18);
    store(CON, 32'h10);
    m_overrun = 1'b0;
    read_at("t3_con_cleared", CON, 1'b0, 32'h08);

    // Test 4: push and pop together while full
    push_and_load("t4_rxd_oldest", 8'hAA);
    read_at("t4_con_no_overrun", CON, 1'b0, 32'h08);
    push_rx(8'hBB, m_overrun);
    read_at("t4_con_still_full", CON, 1'b0, 32'h18);
    for (int i = 0; i < 4; i++) load_rxd($sformatf("t4_drain_%0d", i));
    read_at("t4_con_drained", CON, 1'b0, 32'h10);
    store(CON, 32'h10);
    m_overrun = 1'b0;
    read_at("t4_con_clean", CON, 1'b0, 32'h00);

    // Test 5: back-to-back TX bytes, third store ignored
    base_starts = n_tx_starts;
    tx_q.push_back(8'h41);
    store(TXD, 32'h41);
    done = 1'b0;
    for (int i = 0; i < 8 && !done; i++) begin
      @(negedge clk);
      addr = CON;
      #1 if (rdata[2] == 1'b0) done = 1'b1;
    end
    check("t5_pending_released", {31'h0, done}, 32'h1);
    tx_q.push_back(8'h42);
    store(TXD, 32'h42);
    read_at("t5_con_pending_busy", CON, 1'b0, 32'h06);
    store(TXD, 32'h43);
    done = 1'b0;
    for (int i = 0; i < 80 && !done; i++) begin
      @(negedge clk);
      addr = CON;
      #1 if (rdata == 32'h0 && tx_q.size() == 0 &&
             n_tx_starts == base_starts + 2) done = 1'b1;
    end
    check("t5_tx_complete_in_time", {31'h0, done}, 32'h1);
    idle(20);
    check("t5_tx_start_count", 32'(n_tx_starts - base_starts), 32'd2);
    check("t5_tx_queue_empty", 32'(tx_q.size()), 32'd0);
    read_at("t5_con_idle", CON, 1'b0, 32'h00);

    // Test 6: irq follows FIFO occupancy
    store(CON, 32'h1);
    check("t6_irq_empty", {31'h0, irq}, 32'h0);
    push_rx(8'h77, m_overrun);
    check("t6_irq_after_push", {31'h0, irq}, 32'h1);
    read_at("t6_unmatched_rd", RXD + 32'd1, 1'b1, 32'h0);
    read_at("t6_unmatched_hi", BASE + 32'd12, 1'b1, 32'h0);
    check("t6_irq_after_unmatched", {31'h0, irq}, 32'h1);
    load_rxd("t6_rxd");
    check("t6_irq_after_pop", {31'h0, irq}, 32'h0);
    read_at("t6_con_final", CON, 1'b0, 32'h01);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
